spi_burst_reader: RTL and testbench

//  Parametrised SPI-master burst reader for register-mapped sensors such as the PmodACL2 (ADXL362).
//  On fetch it sends a command byte and a start address, then clocks in NBYTES data bytes.
//  It presents them as one packed word with a ready/fetch/arrived handshake.

---
 rtl/spi_burst_reader.sv | 109 ++++++++++
 tb/tb_spi_burst_reader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_reader.sv
// SPI mode-0 burst reader: sends CMD, ADDR, then clocks in NBYTES bytes into one packed word.
// Burst takes 2*CLK_DIV*(16+8*NBYTES) cycles, then CS_GAP*CLK_DIV cycles; fetch is ignored while ready=0.
module spi_burst_reader #(
  parameter int         CLK_DIV = 4,
  parameter int         NBYTES  = 4,
  parameter logic [7:0] CMD     = 8'h0B,
  parameter logic [7:0] ADDR    = 8'h0E,
  parameter int         CS_GAP  = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  fetch,
  output logic                  ready,
  output logic                  arrived,
  output logic [8*NBYTES-1:0]   data,
  output logic                  SCLK,
  input  logic                  MISO,
  output logic                  MOSI,
  output logic                  CS
);

  localparam int B  = 16 + 8 * NBYTES;
  localparam int HW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(B + 1);
  localparam int GW = $clog2(CS_GAP * CLK_DIV + 1);

  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_END  = HW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] B_ALL  = BW'(B);
  localparam logic [BW-1:0] B_HDR  = BW'(16);
  localparam logic [GW-1:0] G_END  = GW'(CS_GAP * CLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]          state;
  logic [HW-1:0]       hcnt;
  logic [BW-1:0]       bcnt;
  logic [GW-1:0]       gcnt;
  logic [15:0]         txsr;
  logic [8*NBYTES-1:0] rxsr;
  logic [8*NBYTES-1:0] word;

  assign ready = (state == S_IDLE);
  assign MOSI  = txsr[15];

  // rxsr holds the first received byte in its top bits; reorder so byte k lands at data[8k+:8]
  always_comb begin
    word = '0;
    for (int k = 0; k < NBYTES; k++) begin
      word[8*k +: 8] = rxsr[8*(NBYTES-1-k) +: 8];
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      hcnt    <= '0;
      bcnt    <= '0;
      gcnt    <= '0;
      txsr    <= '0;
      rxsr    <= '0;
      data    <= '0;
      arrived <= 1'b0;
      SCLK    <= 1'b0;
      CS      <= 1'b1;
    end else begin
      arrived <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fetch) begin
            state <= S_SHIFT;
            CS    <= 1'b0;
            hcnt  <= '0;
            bcnt  <= '0;
            txsr  <= {CMD, ADDR};
          end
        end
        S_SHIFT: begin
          hcnt <= (hcnt == H_END) ? '0 : hcnt + HW'(1);
          if (hcnt == H_LAST) begin
            SCLK <= 1'b1;
            bcnt <= bcnt + BW'(1);
            // command/address phase returns nothing useful
            if (bcnt >= B_HDR) rxsr <= {rxsr[8*NBYTES-2:0], MISO};
          end
          if (hcnt == H_END) begin
            SCLK <= 1'b0;
            txsr <= {txsr[14:0], 1'b0};
            if (bcnt == B_ALL) begin
              state   <= S_GAP;
              CS      <= 1'b1;
              data    <= word;
              arrived <= 1'b1;
              gcnt    <= '0;
            end
          end
        end
        S_GAP: begin
          if (gcnt == G_END) state <= S_IDLE;
          else               gcnt  <= gcnt + GW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_reader.sv
// Directed/randomized bench for spi_burst_reader: a byte-stream SPI slave model plus protocol counters.
module tb_spi_burst_reader;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic Reset = 1'b0;
  logic fetch_a = 1'b0, fetch_b = 1'b0;
  logic ready_a, arrived_a, sclk_a, miso_a, mosi_a, cs_a;
  logic ready_b, arrived_b, sclk_b, miso_b, mosi_b, cs_b;
  logic [31:0] data_a;
  logic [7:0]  data_b;

  spi_burst_reader #(.CLK_DIV(2), .NBYTES(4), .CS_GAP(2)) dut_a (
    .Clock(Clock), .Reset(Reset), .fetch(fetch_a), .ready(ready_a), .arrived(arrived_a),
    .data(data_a), .SCLK(sclk_a), .MISO(miso_a), .MOSI(mosi_a), .CS(cs_a));

  spi_burst_reader #(.CLK_DIV(1), .NBYTES(1), .CS_GAP(2)) dut_b (
    .Clock(Clock), .Reset(Reset), .fetch(fetch_b), .ready(ready_b), .arrived(arrived_b),
    .data(data_b), .SCLK(sclk_b), .MISO(miso_b), .MOSI(mosi_b), .CS(cs_b));

  // Slave model: serial bit stream, first bit presented at CS fall, advanced on each SCLK fall
  logic [47:0] stream_a = '0;
  logic [23:0] stream_b = '0;
  int idx_a = 0, idx_b = 0;
  always @(negedge sclk_a or posedge cs_a) if (cs_a) idx_a = 0; else idx_a = idx_a + 1;
  always @(negedge sclk_b or posedge cs_b) if (cs_b) idx_b = 0; else idx_b = idx_b + 1;
  assign miso_a = (idx_a < 48) ? stream_a[47 - idx_a] : 1'b0;
  assign miso_b = (idx_b < 24) ? stream_b[23 - idx_b] : 1'b0;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int cslow_a, rises_a, viol_a, arr_a, arr_cyc_a, hi_a, gap_a, rdy_cyc_a;
  int cslow_b, rises_b, arr_b, arr_cyc_b;
  logic [15:0] mosi16_a;
  logic psclk_a = 1'b0, pready_a = 1'b1, psclk_b = 1'b0;

  always @(negedge Clock) begin
    if (!cs_a) cslow_a++;
    if (sclk_a && !psclk_a) begin
      rises_a++;
      if (rises_a <= 16) mosi16_a = {mosi16_a[14:0], mosi_a};
    end
    psclk_a = sclk_a;
    if (cs_a && sclk_a) viol_a++;
    if (arrived_a) begin arr_a++; arr_cyc_a = cyc; end
    if (cs_a) hi_a++;
    else if (hi_a > 0) begin gap_a = hi_a; hi_a = 0; end
    if (ready_a && !pready_a) rdy_cyc_a = cyc;
    pready_a = ready_a;
    if (!cs_b) cslow_b++;
    if (sclk_b && !psclk_b) rises_b++;
    psclk_b = sclk_b;
    if (arrived_b) begin arr_b++; arr_cyc_b = cyc; end
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic clear_counts();
    cslow_a = 0; rises_a = 0; viol_a = 0; arr_a = 0; arr_cyc_a = -1; mosi16_a = '0;
    cslow_b = 0; rises_b = 0; arr_b = 0; arr_cyc_b = -1;
  endtask

  // Raise fetch before an edge; returns the cycle number of the edge that sampled it
  task automatic fire(input bit which, output int e);
    if (which) fetch_b = 1'b1; else fetch_a = 1'b1;
    @(posedge Clock);
    #1;
    e = cyc;
    fetch_a = 1'b0;
    fetch_b = 1'b0;
  endtask

  task automatic wait_arr(input bit which, input int target, input string tag);
    for (int i = 0; i < 500 && (which ? arr_b : arr_a) < target; i++) tick();
    check(tag, which ? arr_b : arr_a, target);
  endtask

  task automatic wait_ready_a();
    for (int i = 0; i < 50 && !ready_a; i++) tick();
    check("ready_return", ready_a, 1'b1);
  endtask

  logic [7:0]  bt [4];
  logic [15:0] dummy;
  logic [31:0] exp_a, exp2_a;
  logic [7:0]  exp_b;
  int e, first_arr;

  initial begin
    clear_counts();
    hi_a = 0; gap_a = 0; rdy_cyc_a = -1;
    repeat (3) tick();
    check("rst_ready", ready_a, 1'b1);
    check("rst_arrived", arrived_a, 1'b0);
    check("rst_data", data_a, 32'h0);
    check("rst_sclk", sclk_a, 1'b0);
    check("rst_mosi", mosi_a, 1'b0);
    check("rst_cs", cs_a, 1'b1);
    check("rst_data_b", data_b, 8'h0);
    Reset = 1'b1;
    tick();

    // Single bursts with random payloads; the first one also gets a stray mid-burst fetch
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 4; k++) bt[k] = 8'($urandom);
      if (it == 0) begin bt[0] = 8'h11; bt[1] = 8'h22; bt[2] = 8'h33; bt[3] = 8'h44; end
      dummy = 16'($urandom);
      stream_a = {dummy, bt[0], bt[1], bt[2], bt[3]};
      exp_a = {bt[3], bt[2], bt[1], bt[0]};
      clear_counts();
      fire(1'b0, e);
      check("cs_after_fetch", cs_a, 1'b0);
      check("ready_after_fetch", ready_a, 1'b0);
      if (it == 0) begin
        repeat (20) tick();
        fetch_a = 1'b1;
        tick();
        fetch_a = 1'b0;
        check("ready_busy", ready_a, 1'b0);
      end
      wait_arr(1'b0, 1, "arrive_a");
      check("data_a", data_a, exp_a);
      check("arrive_cycle_a", arr_cyc_a, e + 192);
      check("mosi_hdr", mosi16_a, 16'h0B0E);
      check("cs_low_cycles", cslow_a, 192);
      check("sclk_rises", rises_a, 48);
      check("sclk_while_cs_high", viol_a, 0);
      wait_ready_a();
      check("ready_cycle", rdy_cyc_a, e + 196);
      repeat (10) tick();
      check("no_extra_burst", arr_a, 1);
      check("cs_idle", cs_a, 1'b1);
      check("data_hold", data_a, exp_a);
    end

    // fetch held high: back-to-back bursts separated by the full gap
    for (int k = 0; k < 4; k++) bt[k] = 8'($urandom);
    stream_a = {16'hFFFF, bt[0], bt[1], bt[2], bt[3]};
    exp_a = {bt[3], bt[2], bt[1], bt[0]};
    clear_counts();
    fetch_a = 1'b1;
    wait_arr(1'b0, 1, "held_arrive1");
    check("held_data1", data_a, exp_a);
    first_arr = arr_cyc_a;
    for (int k = 0; k < 4; k++) bt[k] = 8'($urandom);
    stream_a = {16'h0000, bt[0], bt[1], bt[2], bt[3]};
    exp2_a = {bt[3], bt[2], bt[1], bt[0]};
    wait_arr(1'b0, 2, "held_arrive2");
    fetch_a = 1'b0;
    check("held_data2", data_a, exp2_a);
    check("held_gap", gap_a, 5);
    check("held_period", arr_cyc_a - first_arr, 197);
    wait_ready_a();
    tick();

    // Reset in the middle of a data byte aborts the burst
    stream_a = {16'h0, 32'($urandom)};
    clear_counts();
    fire(1'b0, e);
    repeat (100) tick();
    check("pre_abort_cs", cs_a, 1'b0);
    Reset = 1'b0;
    #1;
    check("abort_cs", cs_a, 1'b1);
    check("abort_sclk", sclk_a, 1'b0);
    check("abort_data", data_a, 32'h0);
    check("abort_ready", ready_a, 1'b1);
    check("abort_arrived", arrived_a, 1'b0);
    tick();
    Reset = 1'b1;
    repeat (250) tick();
    check("abort_no_arrive", arr_a, 0);
    check("abort_data_held", data_a, 32'h0);

    // Minimal config: one byte, one clock per half-period
    exp_b = 8'hA5;
    for (int it = 0; it < 2; it++) begin
      if (it == 1) exp_b = 8'($urandom);
      stream_b = {16'($urandom), exp_b};
      clear_counts();
      fire(1'b1, e);
      wait_arr(1'b1, 1, "arrive_b");
      check("data_b", data_b, exp_b);
      check("cs_low_b", cslow_b, 48);
      check("arrive_cycle_b", arr_cyc_b, e + 48);
      check("rises_b", rises_b, 24);
      repeat (5) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
